// File: rtl/dmem_lsu.sv
// Load/store unit between the CPU datapath and a synchronous data RAM.
// Handles one request at a time: lane-aligned stores, extended loads, and error responses for misaligned or illegal requests.
module dmem_lsu #(
  parameter int word_size    = 32,
  parameter int address_size = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [2:0]              req_funct3,
  input  logic [address_size-1:0] req_addr,
  input  logic [word_size-1:0]    req_wdata,
  output logic                    resp_valid,
  output logic [word_size-1:0]    resp_rdata,
  output logic                    resp_err,
  output logic [address_size-1:0] dmem_addr,
  inout  wire  [word_size-1:0]    dmem_data,
  output logic                    dmem_wen,
  output logic [3:0]              byte_en
);

  typedef enum logic [2:0] {IDLE, WR, RD, RD_CAP, RESP} state_t;

  state_t                  state, state_d;
  logic                    req_ready_d, resp_valid_d, resp_err_d, dmem_wen_d;
  logic [word_size-1:0]    resp_rdata_d;
  logic [address_size-1:0] dmem_addr_d;
  logic [3:0]              byte_en_d;
  logic [word_size-1:0]    wdata_p0, wdata_d;
  logic [2:0]              funct3_p0, funct3_d;
  logic [1:0]              addr_lo_p0, addr_lo_d;

  function automatic logic req_illegal(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    bad = bad || (we && f3[2]);
    bad = bad || ((f3[1:0] == 2'b01) && a[0]);
    bad = bad || ((f3 == 3'b010) && (a != 2'b00));
    return bad;
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [word_size-1:0] load_extend(input logic [word_size-1:0] w,
                                                       input logic [2:0] f3, input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // The bus enable comes straight from the state register so it tracks WR exactly.
  assign dmem_data = (state == WR) ? wdata_p0 : {word_size{1'bz}};

  always_comb begin
    state_d      = state;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    dmem_addr_d  = dmem_addr;
    dmem_wen_d   = 1'b0;
    byte_en_d    = 4'b0000;
    wdata_d      = wdata_p0;
    funct3_d     = funct3_p0;
    addr_lo_d    = addr_lo_p0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          funct3_d  = req_funct3;
          addr_lo_d = req_addr[1:0];
          wdata_d   = req_wdata << {req_addr[1:0], 3'b000};
          if (req_illegal(req_we, req_funct3, req_addr[1:0])) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            dmem_addr_d = {req_addr[address_size-1:2], 2'b00};
            if (req_we) begin
              state_d    = WR;
              dmem_wen_d = 1'b1;
              byte_en_d  = store_mask(req_funct3, req_addr[1:0]);
            end else begin
              state_d   = RD;
              byte_en_d = 4'b1111;
            end
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      RD: state_d = RD_CAP;
      RD_CAP: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = load_extend(dmem_data, funct3_p0, addr_lo_p0);
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      dmem_addr  <= '0;
      dmem_wen   <= 1'b0;
      byte_en    <= 4'b0000;
    end else begin
      state      <= state_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      resp_err   <= resp_err_d;
      dmem_addr  <= dmem_addr_d;
      dmem_wen   <= dmem_wen_d;
      byte_en    <= byte_en_d;
    end
  end

  // Request payload registers carry no reset; they are only read after a fresh accept.
  always_ff @(posedge clk) begin
    wdata_p0   <= wdata_d;
    funct3_p0  <= funct3_d;
    addr_lo_p0 <= addr_lo_d;
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed testbench for dmem_lsu with a small synchronous-read RAM model on the tri-state bus.
`timescale 1ns/1ps
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] dmem_addr;
  wire  [31:0] dmem_data;
  logic        dmem_wen;
  logic [3:0]  byte_en;

  int checks = 0;
  int passes = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] ram_q;
  logic        ram_oe;
  int          wr_count;
  logic [31:0] wr_log_addr [0:15];
  logic [31:0] wr_log_data [0:15];

  always #5 clk = ~clk;

  dmem_lsu #(.word_size(32), .address_size(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dmem_addr(dmem_addr), .dmem_data(dmem_data), .dmem_wen(dmem_wen), .byte_en(byte_en)
  );

  // RAM: data appears on the bus the cycle after a read address is presented.
  assign dmem_data = ram_oe ? ram_q : 32'hzzzz_zzzz;

  always @(posedge clk) begin
    if (dmem_wen) begin
      for (int i = 0; i < 4; i++)
        if (byte_en[i]) mem[dmem_addr[11:2]][8*i +: 8] <= dmem_data[8*i +: 8];
      if (wr_count < 16) begin
        wr_log_addr[wr_count] <= dmem_addr;
        wr_log_data[wr_count] <= dmem_data;
      end
      wr_count <= wr_count + 1;
    end
    ram_q  <= mem[dmem_addr[11:2]];
    ram_oe <= !dmem_wen && (byte_en == 4'b1111);
  end

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic err, output int wens, output logic [3:0] be,
                         output logic [31:0] bus, output logic [31:0] wa);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = -1; rd = 32'hx; err = 1'bx; wens = 0; be = 4'h0; bus = 32'h0; wa = 32'h0;
    for (int c = 1; c <= 10; c++) begin
      if (dmem_wen) begin
        wens++; be = byte_en; bus = dmem_data; wa = dmem_addr;
      end
      if (resp_valid) begin
        lat = c; rd = resp_rdata; err = resp_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", req_ready); else passes++;
    checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b want 0", resp_valid); else passes++;
    checks++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0)
      $display("FAIL rst_resp got %h/%b want 0/0", resp_rdata, resp_err); else passes++;
    checks++; if (dmem_addr !== 32'h0 || dmem_wen !== 1'b0 || byte_en !== 4'b0000)
      $display("FAIL rst_ram got %h/%b/%b want 0/0/0000", dmem_addr, dmem_wen, byte_en); else passes++;
  endtask

  task automatic test_word;
    int lat, wens; logic [31:0] rd, bus, wa; logic err; logic [3:0] be;
    run_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, lat, rd, err, wens, be, bus, wa);
    checks++; if (wens !== 1 || be !== 4'b1111 || wa !== 32'h100 || bus !== 32'hDEADBEEF)
      $display("FAIL sw_port got wens=%0d be=%b addr=%h bus=%h want 1/1111/100/deadbeef", wens, be, wa, bus); else passes++;
    checks++; if (lat !== 2 || err !== 1'b0 || rd !== 32'h0)
      $display("FAIL sw_resp got lat=%0d err=%b rd=%h want 2/0/0", lat, err, rd); else passes++;
    run_req(1'b0, 3'b010, 32'h100, 32'h0, lat, rd, err, wens, be, bus, wa);
    checks++; if (lat !== 3 || err !== 1'b0 || rd !== 32'hDEADBEEF || wens !== 0)
      $display("FAIL lw got lat=%0d err=%b rd=%h wens=%0d want 3/0/deadbeef/0", lat, err, rd, wens); else passes++;
  endtask

  task automatic test_byte;
    int lat, wens; logic [31:0] rd, bus, wa; logic err; logic [3:0] be;
    run_req(1'b1, 3'b000, 32'h103, 32'h000000A5, lat, rd, err, wens, be, bus, wa);
    checks++; if (wens !== 1 || be !== 4'b1000 || wa !== 32'h100 || bus !== 32'hA5000000 || lat !== 2)
      $display("FAIL sb got wens=%0d be=%b addr=%h bus=%h lat=%0d want 1/1000/100/a5000000/2", wens, be, wa, bus, lat); else passes++;
    checks++; if (mem[32'h100 >> 2] !== 32'hA5ADBEEF)
      $display("FAIL sb_merge got %h want a5adbeef", mem[32'h100 >> 2]); else passes++;
    run_req(1'b0, 3'b000, 32'h103, 32'h0, lat, rd, err, wens, be, bus, wa);
    checks++; if (rd !== 32'hFFFFFFA5 || lat !== 3 || err !== 1'b0)
      $display("FAIL lb got rd=%h lat=%0d want ffffffa5/3", rd, lat); else passes++;
    run_req(1'b0, 3'b100, 32'h103, 32'h0, lat, rd, err, wens, be, bus, wa);
    checks++; if (rd !== 32'h000000A5 || lat !== 3)
      $display("FAIL lbu got rd=%h lat=%0d want 000000a5/3", rd, lat); else passes++;
    run_req(1'b0, 3'b000, 32'h101, 32'h0, lat, rd, err, wens, be, bus, wa);
    checks++; if (rd !== 32'hFFFFFFBE)
      $display("FAIL lb_lane1 got %h want ffffffbe", rd); else passes++;
    run_req(1'b0, 3'b100, 32'h100, 32'h0, lat, rd, err, wens, be, bus, wa);
    checks++; if (rd !== 32'h000000EF)
      $display("FAIL lbu_lane0 got %h want 000000ef", rd); else passes++;
  endtask

  task automatic test_half;
    int lat, wens; logic [31:0] rd, bus, wa; logic err; logic [3:0] be;
    run_req(1'b1, 3'b001, 32'h202, 32'h00008001, lat, rd, err, wens, be, bus, wa);
    checks++; if (wens !== 1 || be !== 4'b1100 || wa !== 32'h200 || bus !== 32'h80010000 || lat !== 2)
      $display("FAIL sh got wens=%0d be=%b addr=%h bus=%h lat=%0d want 1/1100/200/80010000/2", wens, be, wa, bus, lat); else passes++;
    run_req(1'b0, 3'b001, 32'h202, 32'h0, lat, rd, err, wens, be, bus, wa);
    checks++; if (rd !== 32'hFFFF8001 || lat !== 3)
      $display("FAIL lh got rd=%h lat=%0d want ffff8001/3", rd, lat); else passes++;
    run_req(1'b0, 3'b101, 32'h202, 32'h0, lat, rd, err, wens, be, bus, wa);
    checks++; if (rd !== 32'h00008001)
      $display("FAIL lhu got %h want 00008001", rd); else passes++;
    run_req(1'b0, 3'b001, 32'h100, 32'h0, lat, rd, err, wens, be, bus, wa);
    checks++; if (rd !== 32'hFFFFBEEF)
      $display("FAIL lh_low got %h want ffffbeef", rd); else passes++;
    run_req(1'b0, 3'b101, 32'h100, 32'h0, lat, rd, err, wens, be, bus, wa);
    checks++; if (rd !== 32'h0000BEEF)
      $display("FAIL lhu_low got %h want 0000beef", rd); else passes++;
  endtask

  task automatic test_errors;
    int lat, wens, wc0; logic [31:0] rd, bus, wa; logic err; logic [3:0] be;
    logic        e_we [0:3];
    logic [2:0]  e_f3 [0:3];
    logic [31:0] e_a  [0:3];
    e_we[0] = 1'b0; e_f3[0] = 3'b010; e_a[0] = 32'h101;
    e_we[1] = 1'b1; e_f3[1] = 3'b001; e_a[1] = 32'h203;
    e_we[2] = 1'b0; e_f3[2] = 3'b011; e_a[2] = 32'h100;
    e_we[3] = 1'b1; e_f3[3] = 3'b100; e_a[3] = 32'h100;
    wc0 = wr_count;
    for (int i = 0; i < 4; i++) begin
      run_req(e_we[i], e_f3[i], e_a[i], 32'h12345678, lat, rd, err, wens, be, bus, wa);
      checks++; if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || wens !== 0)
        $display("FAIL err_%0d got lat=%0d err=%b rd=%h wens=%0d want 1/1/0/0", i, lat, err, rd, wens); else passes++;
    end
    checks++; if (wr_count !== wc0 || mem[32'h100 >> 2] !== 32'hA5ADBEEF || mem[32'h200 >> 2] !== 32'h80010000)
      $display("FAIL err_ram got writes=%0d w100=%h w200=%h want %0d/a5adbeef/80010000",
               wr_count - wc0, mem[32'h100 >> 2], mem[32'h200 >> 2], 0); else passes++;
  endtask

  task automatic test_back_to_back;
    int n_acc, n_resp, n_busy, wc0;
    logic hs;
    logic [31:0] s_a [0:2];
    logic [31:0] s_d [0:2];
    s_a[0] = 32'h300; s_d[0] = 32'h11111111;
    s_a[1] = 32'h304; s_d[1] = 32'h22222222;
    s_a[2] = 32'h308; s_d[2] = 32'h33333333;
    n_acc = 0; n_resp = 0; n_busy = 0; wc0 = wr_count;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = s_a[0]; req_wdata = s_d[0];
    for (int c = 0; c < 16; c++) begin
      hs = req_valid && req_ready;
      @(negedge clk);
      if (hs) begin
        n_acc++;
        if (n_acc < 3) begin
          req_addr = s_a[n_acc]; req_wdata = s_d[n_acc];
        end else req_valid = 1'b0;
      end
      if (resp_valid) n_resp++;
      if (!req_ready) n_busy++;
    end
    req_valid = 1'b0;
    checks++; if (n_acc !== 3 || n_resp !== 3)
      $display("FAIL b2b_count got acc=%0d resp=%0d want 3/3", n_acc, n_resp); else passes++;
    checks++; if (n_busy !== 6)
      $display("FAIL b2b_busy got %0d ready-low cycles want 6", n_busy); else passes++;
    checks++; if (wr_count - wc0 !== 3)
      $display("FAIL b2b_writes got %0d want 3", wr_count - wc0); else passes++;
    for (int i = 0; i < 3; i++) begin
      checks++; if (wr_log_addr[wc0 + i] !== s_a[i] || wr_log_data[wc0 + i] !== s_d[i])
        $display("FAIL b2b_order_%0d got %h:%h want %h:%h", i, wr_log_addr[wc0 + i], wr_log_data[wc0 + i], s_a[i], s_d[i]);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_load;
    int n_resp;
    n_resp = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    if (resp_valid) n_resp++;
    checks++; if (req_ready !== 1'b1 || dmem_wen !== 1'b0 || byte_en !== 4'b0000)
      $display("FAIL rst_mid got ready=%b wen=%b be=%b want 1/0/0000", req_ready, dmem_wen, byte_en); else passes++;
    @(negedge clk);
    if (resp_valid) n_resp++;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (resp_valid) n_resp++;
    end
    checks++; if (n_resp !== 0)
      $display("FAIL rst_mid_resp got %0d pulses want 0", n_resp); else passes++;
    checks++; if (req_ready !== 1'b1 || dmem_wen !== 1'b0 || byte_en !== 4'b0000)
      $display("FAIL rst_after got ready=%b wen=%b be=%b want 1/0/0000", req_ready, dmem_wen, byte_en); else passes++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    ram_q = 32'h0; ram_oe = 1'b0; wr_count = 0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    test_reset;
    rst = 1'b0;
    test_word;
    test_byte;
    test_half;
    test_errors;
    test_back_to_back;
    test_reset_mid_load;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit between the cpu datapath and the data RAM.
- Accepts one load or store request at a time over a valid/ready handshake and drives the RAM port (addr, bidirectional data, wen, byte_en).
- Stores: lane-aligns write data and generates byte enables.
- Loads: captures the RAM word, then extracts and sign- or zero-extends the addressed byte/halfword.
- Rejects misaligned or illegal-width requests with an error response and performs no RAM access.

Parameters:
- word_size, 32, data width in bits; only 32 is supported.
- address_size, 32, byte-address width in bits.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- req_valid  input  1  request present
- req_ready  output  1  LSU can accept a request
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  input  address_size  byte address
- req_wdata  input  word_size  store data, value in low bits
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  word_size  extended load data; 0 for stores and errors
- resp_err  output  1  misaligned or illegal funct3; valid only with resp_valid
- dmem_addr  output  address_size  word address to RAM: req_addr with bits[1:0] forced to 00
- dmem_data  inout  word_size  RAM data bus; LSU drives it only in WR, otherwise high-Z
- dmem_wen  output  1  RAM write enable
- byte_en  output  4  RAM byte lanes; bit i = bits[8i+7:8i]

Behaviour:
- All outputs are registered, except that the dmem_data tri-state enable is taken from the state register.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, dmem_addr=0, dmem_wen=0, byte_en=0000, dmem_data high-Z, state=IDLE.
- Reset applies at the next clk edge in any state. An in-flight request is dropped with no response. A WR cycle in progress still writes on that edge, because the RAM samples on the same edge.
- FSM states: IDLE, WR, RD, RD_CAP, RESP.
- IDLE:
  - req_ready=1. Handshake is req_valid && req_ready on a rising edge.
  - On accept, latch we, funct3, addr[1:0], and the shifted data.
  - Illegal funct3 (011, 110, 111), store with funct3 100/101, H with addr[0]=1, or W with addr[1:0]!=00 -> go to RESP with err=1.
  - Otherwise store -> WR, load -> RD.
- req_ready=0 in every state except IDLE. req_valid while busy is ignored; no queueing.
- WR (exactly 1 cycle):
  - dmem_wen=1, dmem_data = req_wdata shifted left by 8*addr[1:0].
  - byte_en: B = 0001 << addr[1:0]; H = 0011 << addr[1:0]; W = 1111.
  - Next state RESP.
- RD (1 cycle): dmem_wen=0, byte_en=1111, bus high-Z. The RAM returns data one cycle after the address is presented. Next state RD_CAP.
- RD_CAP (1 cycle): register dmem_data.
  - Select lane: byte = word[8*a+7:8*a]; half = word[16*a1+15:16*a1].
  - Sign-extend for B/H, zero-extend for BU/HU, pass W unchanged.
  - Next state RESP.
- RESP (1 cycle): resp_valid=1 with resp_rdata/resp_err. dmem_wen=0, byte_en=0000. Next state IDLE, with req_ready=1 on the following cycle.
- Latency, for accept at edge N:
  - Store: wen high during cycle N..N+1, resp_valid during N+1..N+2.
  - Load: resp_valid 3 cycles after accept.
  - Error: resp_valid 1 cycle after accept.
- Back-to-back requests: the earliest next accept is the edge at which RESP leaves to IDLE, plus one cycle. Throughput is 1 request per 3 cycles (store) or 4 cycles (load).
- dmem_wen is never high outside WR. The bus is never driven while dmem_wen=0.

Test Plan:
- Reset: hold rst for 2 cycles mid-load -> req_ready=1, resp_valid never pulses, dmem_wen=0, byte_en=0000, bus high-Z.
- SW addr 0x100, data 0xDEADBEEF -> one cycle with wen=1, byte_en=1111, dmem_addr=0x100, bus=0xDEADBEEF; then resp_valid=1, err=0; LW 0x100 returns 0xDEADBEEF after 3 cycles.
- SB addr 0x103, data 0x000000A5 -> byte_en=1000, bus=0xA5000000. Then LB 0x103 -> 0xFFFFFFA5; LBU 0x103 -> 0x000000A5.
- SH addr 0x202, data 0x8001 -> byte_en=1100, bus=0x80010000. LH 0x202 -> 0xFFFF8001; LHU 0x202 -> 0x00008001.
- Misaligned/illegal: LW 0x101, SH 0x203, funct3=011 -> resp_valid 1 cycle after accept, err=1, rdata=0, no wen pulse, RAM contents unchanged.
- Busy: hold req_valid high continuously across 3 stores -> exactly 3 accepts, req_ready low while busy, 3 resp pulses, each write landing once in order.
